op_amp_cal_ctrl: RTL and testbench
==================================

OP_AMP_CAL_CTRL -- requirements
Module: op_amp_cal_ctrl

Interface
REQ-001 SHALL have parameter NSAMP_LOG2, default 4, log2 of offset-calibration sample count (range 1..8).
REQ-002 SHALL have parameter SETTLE, default 3, cycles the differential amplifier inputs are held at zero before sampling (min 2).
REQ-003 SHALL have parameter RECAL_PERIOD, default 65536, RUN-state cycles between automatic recalibrations.
REQ-004 SHALL have ports (one clock; reset asynchronous, active-low):
  clk  in  1  clock
  rst_n  in  1  asynchronous active-low reset
  cal_start  in  1  request calibration (level, sampled each cycle)
  null_req  in  1  requested amplifier offset-null setting
  in_p  in  16 signed  channel positive input
  in_m  in  16 signed  channel negative input
  amp_out  in  16 signed  differential amplifier registered output
  amp_v_plus  out  16 signed  to amplifier v_plus
  amp_v_minus  out  16 signed  to amplifier v_minus
  amp_null1  out  1  to amplifier offset_null1
  amp_null2  out  1  to amplifier offset_null2
  corr_out  out  16 signed  offset-corrected result
  corr_valid  out  1  corr_out valid
  cal_busy  out  1  calibration in progress
  cal_done  out  1  one-cycle pulse at calibration completion
  offset_est  out  16 signed  current offset estimate

Function
REQ-005 SHALL implement FSM states RUN, SETTLE_S, ACCUM, UPDATE.
REQ-006 RUN -> SETTLE_S when cal_start=1, recal timer expires, or null setting changes (REQ-013); otherwise stay RUN.
REQ-007 SETTLE_S: amp_v_plus=amp_v_minus=0 for exactly SETTLE cycles, then -> ACCUM; accumulator cleared on entry.
REQ-008 ACCUM: amp inputs held at 0; amp_out added, sign-extended, to a (16+NSAMP_LOG2)-bit accumulator each cycle for exactly 2^NSAMP_LOG2 cycles, then -> UPDATE.
REQ-009 UPDATE (1 cycle): offset_est <= accumulator arithmetic-shifted right NSAMP_LOG2 (floor); cal_done=1 this cycle only; -> RUN.
REQ-010 Total calibration SHALL take SETTLE + 2^NSAMP_LOG2 + 1 cycles; cal_busy=1 in SETTLE_S, ACCUM, UPDATE.
REQ-011 RUN: amp_v_plus=in_p, amp_v_minus=in_m (registered, 1-cycle latency); corr_out <= sat16(amp_out - offset_est), computed 17-bit, clamped to [-32768, 32767]; 1-cycle latency from amp_out.
REQ-012 corr_valid SHALL be 0 outside RUN and for the first 2 RUN cycles after UPDATE (pipeline refill), 1 otherwise once at least one calibration has completed.
REQ-013 null_req registered into amp_null1 and amp_null2 (both equal) only in RUN; a change from the current value SHALL apply in the same cycle as the RUN -> SETTLE_S transition.
REQ-014 null_req changes during calibration SHALL be ignored until RUN, then trigger a further calibration.
REQ-015 cal_start or timer expiry during calibration SHALL be ignored (not queued).
REQ-016 Recal timer counts only in RUN, reloads to RECAL_PERIOD-1 on entering SETTLE_S, expires at 0.
REQ-017 Simultaneous cal_start, expiry and null change SHALL start exactly one calibration.

Reset
REQ-018 While rst_n=0: state SETTLE_S (automatic calibration after release), amp_v_plus=amp_v_minus=0, amp_null1=amp_null2=0, corr_out=0, corr_valid=0, cal_busy=1, cal_done=0, offset_est=0, accumulator and counters 0, timer RECAL_PERIOD-1.
REQ-019 Reset asserted mid-calibration SHALL abort it; partial accumulation discarded; offset_est returns to 0.

Structure
REQ-020 FSM state encoding, sat16 limits and the 16-bit sample width SHALL live in shared package op_amp_pkg.
REQ-021 Saturating subtract SHALL be sub-module op_amp_sat_sub (17-bit difference, 16-bit clamp, combinational).

Verification
REQ-022 Amp model offset -5 (nulls low, zero inputs give -5): after reset release, cal_done at cycle 20 (defaults), offset_est=-5.
REQ-023 After REQ-022, in_p=100, in_m=40 -> amp_out 55 -> corr_out=60, corr_valid=1.
REQ-024 offset_est=-5, amp_out=32767 -> corr_out=32767 (saturated); offset_est=+3, amp_out=-32767 -> corr_out=-32768.
REQ-025 null_req 0->1 in RUN -> amp_null1=amp_null2=1, calibration runs, offset_est=0.
REQ-026 rst_n pulsed low during ACCUM -> outputs at reset values, fresh full calibration follows; cal_start held during calibration -> exactly one cal_done, then a second calibration.
REQ-027 RECAL_PERIOD=16, no stimulus -> cal_done pulses every 16+20 cycles.

Source files
------------

// File: rtl/op_amp_pkg.sv
// op_amp_pkg: shared FSM encoding, sample width and saturation limits for the op-amp calibration controller
package op_amp_pkg;
  localparam int SW = 16;
  localparam logic signed [SW-1:0] SAT_MAX = 16'sh7fff;
  localparam logic signed [SW-1:0] SAT_MIN = 16'sh8000;
  typedef enum logic [1:0] {RUN, SETTLE_S, ACCUM, UPDATE} cal_state_t;
endpackage

// File: rtl/op_amp_sat_sub.sv
// op_amp_sat_sub: a - b computed at 17 bits and clamped to the signed 16-bit range
module op_amp_sat_sub import op_amp_pkg::*; (
  input  logic signed [SW-1:0] a,
  input  logic signed [SW-1:0] b,
  output logic signed [SW-1:0] y
);
  logic signed [SW:0] d;
  assign d = {a[SW-1], a} - {b[SW-1], b};
  assign y = d[SW] != d[SW-1] ? (d[SW] ? SAT_MIN : SAT_MAX) : d[SW-1:0];
endmodule

// File: rtl/op_amp_cal_ctrl.sv
// op_amp_cal_ctrl: drives a differential amplifier, periodically measures its offset with zeroed inputs and subtracts it
module op_amp_cal_ctrl import op_amp_pkg::*; #(
  parameter int NSAMP_LOG2   = 4,
  parameter int SETTLE       = 3,
  parameter int RECAL_PERIOD = 65536
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cal_start,
  input  logic                 null_req,
  input  logic signed [SW-1:0] in_p,
  input  logic signed [SW-1:0] in_m,
  input  logic signed [SW-1:0] amp_out,
  output logic signed [SW-1:0] amp_v_plus,
  output logic signed [SW-1:0] amp_v_minus,
  output logic                 amp_null1,
  output logic                 amp_null2,
  output logic signed [SW-1:0] corr_out,
  output logic                 corr_valid,
  output logic                 cal_busy,
  output logic                 cal_done,
  output logic signed [SW-1:0] offset_est
);
  localparam int NS = 1 << NSAMP_LOG2;
  localparam int AW = SW + NSAMP_LOG2;
  localparam int CW = $clog2(SETTLE + NS + 1);
  localparam int TW = $clog2(RECAL_PERIOD + 1);
  cal_state_t state, nstate;
  logic [CW-1:0] cnt;
  logic [TW-1:0] timer;
  logic signed [AW-1:0] acc;
  logic [1:0] fill;
  logic signed [SW-1:0] diff;
  logic go;
  op_amp_sat_sub u_sub (.a(amp_out), .b(offset_est), .y(diff));
  assign go = cal_start || timer == '0 || null_req != amp_null1;
  assign cal_busy = state != RUN;
  assign cal_done = state == UPDATE;
  assign corr_valid = state == RUN && fill == 2'd2;
  always_comb begin
    nstate = state;
    case (state)
      RUN:      if (go) nstate = SETTLE_S;
      SETTLE_S: if (cnt == CW'(SETTLE - 1)) nstate = ACCUM;
      ACCUM:    if (cnt == CW'(NS - 1)) nstate = UPDATE;
      default:  nstate = RUN;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state       <= SETTLE_S;
      cnt         <= '0;
      timer       <= TW'(RECAL_PERIOD - 1);
      acc         <= '0;
      fill        <= '0;
      offset_est  <= '0;
      amp_v_plus  <= '0;
      amp_v_minus <= '0;
      amp_null1   <= 1'b0;
      amp_null2   <= 1'b0;
      corr_out    <= '0;
    end else begin
      state       <= nstate;
      cnt         <= nstate != state ? '0 : cnt + CW'(1);
      timer       <= state != RUN ? timer : go ? TW'(RECAL_PERIOD - 1) : timer - TW'(1);
      acc         <= state == ACCUM ? acc + {{NSAMP_LOG2{amp_out[SW-1]}}, amp_out} : state == SETTLE_S ? '0 : acc;
      fill        <= state != RUN ? 2'd0 : fill == 2'd2 ? fill : fill + 2'd1;
      offset_est  <= state == UPDATE ? acc[AW-1:NSAMP_LOG2] : offset_est;
      amp_v_plus  <= nstate == RUN ? in_p : '0;
      amp_v_minus <= nstate == RUN ? in_m : '0;
      amp_null1   <= state == RUN ? null_req : amp_null1;
      amp_null2   <= state == RUN ? null_req : amp_null2;
      corr_out    <= state == RUN ? diff : corr_out;
    end
endmodule

// File: tb/tb_op_amp_cal_ctrl.sv
// tb_op_amp_cal_ctrl: randomized self-checking bench with an amplifier model and a behavioural reference
module tb_op_amp_cal_ctrl;
  import op_amp_pkg::*;
  localparam int NL = 4, ST = 3, NS = 1 << NL, T = ST + NS + 1, RP = 65536, RPR = 16;
  logic clk = 0, rst_n = 0, rst_nr = 0;
  logic cal_start = 0, null_req = 0;
  logic signed [15:0] in_p = 0, in_m = 0, amp_out = 0, amp_out_r = 0;
  logic signed [15:0] amp_v_plus, amp_v_minus, corr_out, offset_est;
  logic amp_null1, amp_null2, corr_valid, cal_busy, cal_done;
  logic signed [15:0] vp_r, vm_r, corr_r, off_r;
  logic n1_r, n2_r, cv_r, busy_r, done_r;
  int checks = 0, failures = 0;
  int amp_offs = -5;
  bit noise_en = 0;
  always #5 clk = ~clk;

  op_amp_cal_ctrl dut (
    .clk(clk), .rst_n(rst_n), .cal_start(cal_start), .null_req(null_req),
    .in_p(in_p), .in_m(in_m), .amp_out(amp_out),
    .amp_v_plus(amp_v_plus), .amp_v_minus(amp_v_minus), .amp_null1(amp_null1), .amp_null2(amp_null2),
    .corr_out(corr_out), .corr_valid(corr_valid), .cal_busy(cal_busy), .cal_done(cal_done), .offset_est(offset_est)
  );
  op_amp_cal_ctrl #(.RECAL_PERIOD(RPR)) dut_r (
    .clk(clk), .rst_n(rst_nr), .cal_start(1'b0), .null_req(1'b0),
    .in_p(16'sd0), .in_m(16'sd0), .amp_out(amp_out_r),
    .amp_v_plus(vp_r), .amp_v_minus(vm_r), .amp_null1(n1_r), .amp_null2(n2_r),
    .corr_out(corr_r), .corr_valid(cv_r), .cal_busy(busy_r), .cal_done(done_r), .offset_est(off_r)
  );

  function automatic logic signed [15:0] sat(input int v);
    return v > 32767 ? 16'h7fff : v < -32768 ? 16'h8000 : 16'(v);
  endfunction
  function automatic int fdiv(input int a, input int b);
    return (a < 0 && a % b != 0) ? a / b - 1 : a / b;
  endfunction
  task automatic cmp(input string nm, input int act, input int want);
    checks++;
    if (act != want) begin
      failures++;
      $display("FAIL %s got %0d want %0d at %0t", nm, act, want, $time);
    end
  endtask
  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  always @(posedge clk) begin
    int nz;
    nz = noise_en ? int'($urandom_range(6)) - 3 : 0;
    amp_out <= sat(int'(amp_v_plus) - int'(amp_v_minus) + (amp_null1 ? 0 : amp_offs) + nz);
    amp_out_r <= sat(int'(vp_r) - int'(vm_r) + (n1_r ? 0 : -5));
  end

  int m_k, m_sum, m_off, m_timer, m_age, e_vp, e_vm, e_corr;
  bit m_cal, m_null;
  always @(posedge clk) begin
    if (!rst_n) begin
      m_cal = 1; m_k = 0; m_sum = 0; m_off = 0; m_timer = RP - 1; m_null = 0; m_age = 0;
      e_vp = 0; e_vm = 0; e_corr = 0;
    end else if (m_cal) begin
      if (m_k >= ST && m_k < ST + NS) m_sum += int'(amp_out);
      if (m_k == T - 1) begin
        m_off = fdiv(m_sum, NS); m_cal = 0; m_age = 0; e_vp = in_p; e_vm = in_m;
      end else begin
        m_k++; e_vp = 0; e_vm = 0;
      end
    end else begin
      e_corr = sat(int'(amp_out) - m_off);
      m_age++;
      if (cal_start || m_timer == 0 || null_req != m_null) begin
        m_cal = 1; m_k = 0; m_sum = 0; m_timer = RP - 1; e_vp = 0; e_vm = 0;
      end else begin
        m_timer--; e_vp = in_p; e_vm = in_m;
      end
      m_null = null_req;
    end
  end

  always @(negedge clk) begin
    cmp("amp_v_plus", int'(amp_v_plus), e_vp);
    cmp("amp_v_minus", int'(amp_v_minus), e_vm);
    cmp("amp_null1", int'(amp_null1), int'(m_null));
    cmp("amp_null2", int'(amp_null2), int'(m_null));
    cmp("cal_busy", int'(cal_busy), int'(m_cal));
    cmp("cal_done", int'(cal_done), int'(m_cal && m_k == T - 1));
    cmp("offset_est", int'(offset_est), m_off);
    cmp("corr_out", int'(corr_out), e_corr);
    cmp("corr_valid", int'(corr_valid), int'(!m_cal && m_age >= 2));
  end

  int cyc = 0, last_done = -1, r_pulses = 0;
  always @(posedge clk) cyc++;
  always @(negedge clk)
    if (rst_nr && done_r) begin
      if (last_done >= 0) cmp("recal_period", cyc - last_done, RPR + T);
      last_done = cyc;
      r_pulses++;
    end

  task automatic wait_done(input string nm, output int n);
    n = 0;
    while (!cal_done && n < 200) begin step(1); n++; end
    if (n >= 200) cmp({nm, "_timeout"}, n, 0);
  endtask

  initial begin
    int n, dones;
    step(3);
    cmp("reset_busy", int'(cal_busy), 1);
    cmp("reset_offset", int'(offset_est), 0);
    rst_n = 1; rst_nr = 1;
    wait_done("first_cal", n);
    cmp("first_done_cycle", n, 19);
    step(1);
    cmp("offset_after_first_cal", int'(offset_est), -5);
    in_p = 100; in_m = 40;
    step(3);
    cmp("corr_60", int'(corr_out), 60);
    cmp("corr_valid_60", int'(corr_valid), 1);
    in_p = 32767; in_m = -5;
    step(3);
    cmp("corr_sat_hi", int'(corr_out), 32767);
    amp_offs = 3; cal_start = 1;
    step(1);
    cal_start = 0;
    wait_done("cal_plus3", n);
    step(1);
    cmp("offset_plus3", int'(offset_est), 3);
    in_p = -32768; in_m = 2;
    step(3);
    cmp("corr_sat_lo", int'(corr_out), -32768);
    amp_offs = -5; cal_start = 1;
    step(1);
    cal_start = 0;
    step(8);
    cmp("in_accum_busy", int'(cal_busy), 1);
    rst_n = 0;
    #1;
    cmp("abort_offset", int'(offset_est), 0);
    cmp("abort_busy", int'(cal_busy), 1);
    cmp("abort_vplus", int'(amp_v_plus), 0);
    cmp("abort_corr_valid", int'(corr_valid), 0);
    step(2);
    rst_n = 1;
    wait_done("recal_after_abort", n);
    cmp("recal_after_abort_cycle", n, 19);
    step(1);
    cmp("offset_after_abort", int'(offset_est), -5);
    null_req = 1;
    step(1);
    cmp("null1_set", int'(amp_null1), 1);
    cmp("null2_set", int'(amp_null2), 1);
    cmp("null_busy", int'(cal_busy), 1);
    wait_done("null_cal", n);
    step(1);
    cmp("offset_nulled", int'(offset_est), 0);
    cal_start = 1;
    dones = 0;
    for (int i = 0; i < 25; i++) begin step(1); dones += int'(cal_done); end
    cal_start = 0;
    cmp("held_start_one_done", dones, 1);
    cmp("held_start_second_busy", int'(cal_busy), 1);
    wait_done("second_cal", n);
    cmp("second_cal_seen", int'(cal_done), 1);
    noise_en = 1;
    for (int i = 0; i < 3000; i++) begin
      cal_start = $urandom_range(39) == 0;
      if ($urandom_range(149) == 0) null_req = ~null_req;
      in_p = 16'($urandom);
      in_m = 16'($urandom);
      if (i % 500 == 0) amp_offs = int'($urandom_range(100)) - 50;
      rst_n = !(i % 1000 == 999);
      step(1);
    end
    rst_n = 1;
    step(5);
    cmp("recal_pulses_seen", int'(r_pulses > 50), 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
